// File: rtl/bsg_hash_bank_router_pkg.sv
// Shared types for the hash bank router: per-bank FIFO state encoding and the
// {index, data} entry layout of the default 4-bank, 16-bit, 32-bit configuration.
package bsg_hash_bank_router_pkg;

  localparam int unsigned entry_index_width = 14;
  localparam int unsigned entry_data_width  = 32;

  typedef enum logic [1:0] {
    FifoEmpty = 2'b00,
    FifoOne   = 2'b01,
    FifoFull  = 2'b10
  } fifo_state_e;

  typedef struct packed {
    logic [entry_index_width-1:0] index;
    logic [entry_data_width-1:0]  data;
  } bank_entry_s;

endpackage

// File: rtl/bsg_hash_bank_router_fifo.sv
// Two-entry per-bank FIFO. The head register always drives the output, so a
// pop from FULL promotes the tail and a pop+push in ONE overwrites the head.
module bsg_hash_bank_router_fifo
  import bsg_hash_bank_router_pkg::*;
#(
  parameter int unsigned width_p = 46
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  fifo_state_e        state_q, state_d;
  logic [width_p-1:0] head_q, head_d;
  logic [width_p-1:0] tail_q, tail_d;
  logic               deq;

  // A yumi against an empty FIFO is dropped rather than corrupting state.
  assign deq = deq_i && (state_q != FifoEmpty);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      FifoEmpty: begin
        if (enq_i) begin
          head_d  = data_i;
          state_d = FifoOne;
        end
      end
      FifoOne: begin
        if (enq_i && deq) begin
          head_d = data_i;
        end else if (enq_i) begin
          tail_d  = data_i;
          state_d = FifoFull;
        end else if (deq) begin
          state_d = FifoEmpty;
        end
      end
      FifoFull: begin
        if (deq) begin
          head_d  = tail_q;
          state_d = FifoOne;
        end
      end
      default: state_d = FifoEmpty;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= FifoEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign full_o = (state_q == FifoFull);
  assign v_o    = (state_q != FifoEmpty);
  assign data_o = head_q;

endmodule

// File: rtl/bsg_hash_bank_router.sv
// Hashes each request address to a (bank, index) pair and steers it into that
// bank's two-entry FIFO; banks drain independently through valid/yumi.
module bsg_hash_bank_router
  import bsg_hash_bank_router_pkg::*;
#(
  parameter int unsigned banks_p        = 4,
  parameter int unsigned width_p        = 16,
  parameter int unsigned data_width_p   = 32,
  localparam int unsigned lg_banks_lp   = (banks_p == 1) ? 0 : $clog2(banks_p),
  localparam int unsigned index_width_lp = width_p - lg_banks_lp
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                v_i,
  input  logic [width_p-1:0]                  addr_i,
  input  logic [data_width_p-1:0]             data_i,
  output logic                                ready_o,
  output logic [banks_p-1:0]                  v_o,
  output logic [banks_p*index_width_lp-1:0]   index_o,
  output logic [banks_p*data_width_p-1:0]     data_o,
  input  logic [banks_p-1:0]                  yumi_i
);

  localparam int unsigned bank_w_lp  = (lg_banks_lp == 0) ? 1 : lg_banks_lp;
  localparam int unsigned entry_w_lp = index_width_lp + data_width_p;

  if ((banks_p > 1) && (width_p < 2 * lg_banks_lp)) begin : g_width_check
    $error("bsg_hash_bank_router: width_p must be at least 2*lg_banks_lp");
  end
  if ((banks_p == 0) || (banks_p > 16) || ((banks_p & (banks_p - 1)) != 0)) begin : g_banks_check
    $error("bsg_hash_bank_router: banks_p must be a power of two in 1..16");
  end

  logic [bank_w_lp-1:0]      bank;
  logic [index_width_lp-1:0] index;
  logic [entry_w_lp-1:0]     wdata;
  logic [banks_p-1:0]        full;
  logic [banks_p-1:0]        enq;

  if (banks_p == 1) begin : g_single
    assign bank  = '0;
    assign index = addr_i;
  end else begin : g_hash
    // Folding in the next k bits spreads strided accesses across banks.
    assign bank  = addr_i[lg_banks_lp-1:0] ^ addr_i[2*lg_banks_lp-1:lg_banks_lp];
    assign index = addr_i[width_p-1:lg_banks_lp];
  end

  assign wdata   = {index, data_i};
  assign ready_o = ~full[bank];

  for (genvar b = 0; b < banks_p; b++) begin : g_bank
    logic [entry_w_lp-1:0] head;

    assign enq[b] = v_i && ready_o && (bank == bank_w_lp'(b));

    bsg_hash_bank_router_fifo #(
      .width_p(entry_w_lp)
    ) u_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .enq_i  (enq[b]),
      .data_i (wdata),
      .deq_i  (yumi_i[b]),
      .full_o (full[b]),
      .v_o    (v_o[b]),
      .data_o (head)
    );

    assign index_o[b*index_width_lp +: index_width_lp] = head[entry_w_lp-1 -: index_width_lp];
    assign data_o[b*data_width_p +: data_width_p]      = head[data_width_p-1:0];

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
      yumi_i[b] |-> v_o[b])
      else $error("bsg_hash_bank_router: yumi_i[%0d] while v_o[%0d]=0", b, b);
`endif
  end

`ifndef SYNTHESIS
  addr_known: assert property (@(posedge clk_i) disable iff (!reset_i)
    v_i |-> !$isunknown(addr_i))
    else $error("bsg_hash_bank_router: X on addr_i with v_i=1");
`endif

endmodule

// File: tb/tb_bsg_hash_bank_router.sv
// Scoreboard bench: directed requests with hand-computed bank/index; a negedge
// monitor tracks per-bank expected queues and checks every pop in order.
module tb_bsg_hash_bank_router;
  import bsg_hash_bank_router_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         req_v;
  logic [15:0]  req_addr;
  logic [31:0]  req_data;
  logic         ready;
  logic [3:0]   v_o;
  logic [55:0]  index_o;
  logic [127:0] data_o;
  logic [3:0]   yumi;

  logic         v1_i;
  logic [15:0]  addr1;
  logic [31:0]  data1;
  logic         ready1;
  logic [0:0]   v1_o;
  logic [15:0]  index1_o;
  logic [31:0]  data1_o;
  logic [0:0]   yumi1;

  logic [1:0]   cur_bank;
  logic [13:0]  cur_index;
  bank_entry_s  q [4][$];
  bank_entry_s  exp_e;
  int           total = 0;
  int           bad   = 0;

  bsg_hash_bank_router #(
    .banks_p(4), .width_p(16), .data_width_p(32)
  ) dut (
    .clk_i(clk), .reset_i(rst_n), .v_i(req_v), .addr_i(req_addr), .data_i(req_data),
    .ready_o(ready), .v_o(v_o), .index_o(index_o), .data_o(data_o), .yumi_i(yumi)
  );

  bsg_hash_bank_router #(
    .banks_p(1), .width_p(16), .data_width_p(32)
  ) dut1 (
    .clk_i(clk), .reset_i(rst_n), .v_i(v1_i), .addr_i(addr1), .data_i(data1),
    .ready_o(ready1), .v_o(v1_o), .index_o(index1_o), .data_o(data1_o), .yumi_i(yumi1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic [1:0] b,
                       input logic [13:0] ix);
    req_v = 1'b1; req_addr = a; req_data = d; cur_bank = b; cur_index = ix;
  endtask

  task automatic idle();
    req_v = 1'b0; req_addr = '0; req_data = '0; cur_bank = 2'd0; cur_index = '0;
  endtask

  // Monitor: checks outputs against the expected queues, then applies handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) q[b].delete();
      chk("reset_v_o", 64'(v_o), 64'h0);
      chk("reset_ready", 64'(ready), 64'h1);
      chk("reset_index", 64'(index_o), 64'h0);
      chk("reset_data", 64'(data_o[63:0]), 64'h0);
    end else begin
      for (int b = 0; b < 4; b++) chk("v_o_model", 64'(v_o[b]), 64'(q[b].size() != 0));
      chk("ready_model", 64'(ready), 64'(q[cur_bank].size() < 2));
      for (int b = 0; b < 4; b++) begin
        if (yumi[b] && v_o[b]) begin
          if (q[b].size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: bank %0d got %h required nothing", b,
                     {index_o[b*14 +: 14], data_o[b*32 +: 32]});
          end else begin
            exp_e = q[b].pop_front();
            chk("pop_order", 64'({index_o[b*14 +: 14], data_o[b*32 +: 32]}), 64'(exp_e));
          end
        end
      end
      if (req_v && ready) q[cur_bank].push_back('{index: cur_index, data: req_data});
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  bank;
    logic [13:0] index;
  } hash_vec_t;

  hash_vec_t vecs [4];

  initial begin
    vecs[0] = '{addr: 16'h000E, bank: 2'd1, index: 14'h0003};
    vecs[1] = '{addr: 16'h0002, bank: 2'd2, index: 14'h0000};
    vecs[2] = '{addr: 16'h0013, bank: 2'd3, index: 14'h0004};
    vecs[3] = '{addr: 16'h00F0, bank: 2'd0, index: 14'h003C};

    rst_n = 1'b0;
    idle();
    yumi = '0;
    v1_i = 1'b0; addr1 = '0; data1 = '0; yumi1 = '0;

    // Reset with random request traffic: nothing may be enqueued.
    for (int i = 0; i < 6; i++) begin
      req_v = 1'($urandom_range(0, 1));
      req_addr = 16'($urandom);
      step();
    end
    idle();
    rst_n = 1'b1;

    // Hash and latency.
    drive(16'h0005, 32'hA, 2'd0, 14'h1);
    step();
    idle();
    @(negedge clk);
    chk("lat_v_o", 64'(v_o), 64'h1);
    chk("lat_index0", 64'(index_o[13:0]), 64'h1);
    chk("lat_data0", 64'(data_o[31:0]), 64'hA);
    step();
    drive(16'h0006, 32'hB, 2'd3, 14'h1);
    step();
    idle();
    @(negedge clk);
    chk("hash6_v_o", 64'(v_o), 64'h9);
    chk("hash6_index3", 64'(index_o[55:42]), 64'h1);
    step();
    yumi = 4'b1001;
    step();
    yumi = '0;

    // One request to every bank, then drain all in one cycle.
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].addr, 32'h200 + 32'(i), vecs[i].bank, vecs[i].index);
      step();
    end
    idle();
    @(negedge clk);
    chk("all_banks_v_o", 64'(v_o), 64'hF);
    step();
    yumi = 4'b1111;
    step();
    yumi = '0;

    // Full back-pressure, pops in order 1, 2, 3.
    drive(16'h0005, 32'h1, 2'd0, 14'h1);
    step();
    drive(16'h0005, 32'h2, 2'd0, 14'h1);
    step();
    drive(16'h0005, 32'h3, 2'd0, 14'h1);
    @(negedge clk);
    chk("full_ready", 64'(ready), 64'h0);
    chk("full_v_o0", 64'(v_o[0]), 64'h1);
    step();
    step();
    yumi = 4'b0001;
    step();
    yumi = '0;
    @(negedge clk);
    chk("full_recover", 64'(ready), 64'h1);
    step();
    idle();
    yumi = 4'b0001;
    step();
    step();
    yumi = '0;

    // Streaming: bank 0 stays in ONE, no stalls, no bubbles.
    for (int i = 0; i < 100; i++) begin
      drive(16'h0005, 32'h1000 + 32'(i), 2'd0, 14'h1);
      yumi = (i > 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("stream_ready", 64'(ready), 64'h1);
      if (i > 0) chk("stream_v_o0", 64'(v_o[0]), 64'h1);
      step();
    end
    idle();
    yumi = 4'b0001;
    step();
    yumi = '0;

    // Cross-bank independence.
    drive(16'h0005, 32'h21, 2'd0, 14'h1);
    step();
    drive(16'h0005, 32'h22, 2'd0, 14'h1);
    step();
    drive(16'h0005, 32'h23, 2'd0, 14'h1);
    @(negedge clk);
    chk("xbank_stall0", 64'(ready), 64'h0);
    step();
    drive(16'h0006, 32'h31, 2'd3, 14'h1);
    @(negedge clk);
    chk("xbank_ready3", 64'(ready), 64'h1);
    step();
    drive(16'h0005, 32'h23, 2'd0, 14'h1);
    @(negedge clk);
    chk("xbank_stall0_again", 64'(ready), 64'h0);
    chk("xbank_v_o", 64'(v_o), 64'h9);
    step();
    idle();
    yumi = 4'b1001;
    step();
    yumi = 4'b0001;
    step();
    yumi = '0;

    // Reset mid-operation drops everything immediately.
    drive(16'h0005, 32'h41, 2'd0, 14'h1);
    step();
    drive(16'h0006, 32'h42, 2'd3, 14'h1);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midreset_v_o", 64'(v_o), 64'h0);
    chk("midreset_ready", 64'(ready), 64'h1);
    step();
    step();
    rst_n = 1'b1;
    drive(16'h0005, 32'h51, 2'd0, 14'h1);
    step();
    idle();
    @(negedge clk);
    chk("post_reset_v_o", 64'(v_o), 64'h1);
    chk("post_reset_data", 64'(data_o[31:0]), 64'h51);
    step();
    yumi = 4'b0001;
    step();
    yumi = '0;

    // Single-bank instance: full address is the index.
    chk("single_ready", 64'(ready1), 64'h1);
    v1_i = 1'b1; addr1 = 16'hBEEF; data1 = 32'hCAFE;
    step();
    v1_i = 1'b0; addr1 = '0; data1 = '0;
    @(negedge clk);
    chk("single_v_o", 64'(v1_o), 64'h1);
    chk("single_index", 64'(index1_o), 64'hBEEF);
    chk("single_data", 64'(data1_o), 64'hCAFE);
    step();
    yumi1 = 1'b1;
    step();
    yumi1 = 1'b0;
    @(negedge clk);
    chk("single_drained", 64'(v1_o), 64'h0);

    chk("queues_drained", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'h0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
